quant_writeback: RTL and testbench
==================================

QUANT_WRITEBACK -- requirements
Module: quant_writeback

Interface
REQ-001 Parameter ARRAY_SIZE, default 16: number of quantized elements per input row.
REQ-002 Parameter OUTPUT_DATA_WIDTH, default 24: width of each input element slot.
REQ-003 Parameter SRAM_DATA_WIDTH, default 32: SRAM write word width; must equal 2x16 bits, and ARRAY_SIZE must be even.
REQ-004 Parameter ADDR_WIDTH, default 10: SRAM word address width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins a transfer; honoured only in IDLE.
REQ-008 base_addr  in  ADDR_WIDTH  first SRAM word address; latched on an honoured start.
REQ-009 num_rows  in  16  number of rows to transfer; latched on an honoured start.
REQ-010 in_valid  in  1  in_data carries a valid row.
REQ-011 in_ready  out  1  block accepts a row this cycle.
REQ-012 in_data  in  ARRAY_SIZE*OUTPUT_DATA_WIDTH  signed quantized row; element i occupies bits [i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH].
REQ-013 sram_wen  out  1  SRAM write enable.
REQ-014 sram_addr  out  ADDR_WIDTH  SRAM write address.
REQ-015 sram_wdata  out  SRAM_DATA_WIDTH  SRAM write data.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse when the transfer completes.
REQ-018 ovf_flag  out  1  sticky out-of-range indicator (see REQ-034).

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, WRITE and DONE.
REQ-020 IDLE + start: latch base_addr and num_rows; go to LOAD if num_rows != 0, otherwise go to DONE.
REQ-021 in_ready SHALL be 1 only in LOAD; a handshake (in_valid & in_ready) captures in_data into a single row register and moves to WRITE.
REQ-022 WRITE SHALL last exactly ARRAY_SIZE/2 cycles (8 at default), with sram_wen=1 and word index k counting 0..ARRAY_SIZE/2-1.
REQ-023 Word k: sram_wdata = {elem[2k+1][15:0], elem[2k][15:0]}.
REQ-024 sram_addr SHALL start at the latched base_addr and increment by 1 per written word across rows, wrapping modulo 2^ADDR_WIDTH.
REQ-025 After the last word of a row: decrement rows remaining; go to LOAD if rows remain, otherwise go to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 Latency: handshake at cycle t gives writes in cycles t+1..t+8 (default), and in_ready is 1 again at t+9; peak throughput is one row per 9 cycles.
REQ-028 start outside IDLE SHALL be ignored, with no effect on the latched address or count.
REQ-029 in_valid outside LOAD SHALL be ignored; in_data need not be held after the handshake.
REQ-030 sram_wen SHALL be 0 in IDLE, LOAD and DONE.

Reset
REQ-031 rst_n low SHALL immediately force: state=IDLE, in_ready=0, sram_wen=0, sram_addr=0, sram_wdata=0, busy=0, done=0, ovf_flag=0, all counters and the row register cleared.
REQ-032 Reset asserted mid-transfer SHALL abort with no further SRAM writes; after release the block waits in IDLE for a new start.

Configuration
REQ-033 Macro QWB_OVF_CHECK_EN controls range checking of input elements.
REQ-034 With QWB_OVF_CHECK_EN defined: each captured element outside [-32768, 32767] SHALL be saturated to the nearest bound before packing, and ovf_flag SHALL be set; ovf_flag is cleared only by reset or an honoured start.
REQ-035 With QWB_OVF_CHECK_EN undefined: elements SHALL be truncated to bits [15:0], and ovf_flag SHALL be constant 0.

Verification
REQ-036 base_addr=0x010, num_rows=1, elem[i]=i -> 8 writes at 0x010..0x017; word 0 = 0x00010000, word 7 = 0x000F000E; done 1 cycle after the last write.
REQ-037 num_rows=0 -> no sram_wen; done pulses the cycle after DONE entry; busy high for exactly one cycle.
REQ-038 base_addr=0x3FC, num_rows=2, in_valid stalled 5 cycles between rows -> addresses 0x3FC..0x3FF then wrap to 0x000..0x00B; in_ready held high through the stall.
REQ-039 QWB_OVF_CHECK_EN defined, elem0=40000, elem1=-40000 -> word 0 = 0x80007FFF and ovf_flag=1; with the macro undefined, word 0 = 0x63C09C40 and ovf_flag=0.
REQ-040 rst_n pulsed low during word 3 of row 1 -> sram_wen=0 immediately and all outputs at reset values; a new start with base_addr=0 then writes from 0x000.
REQ-041 start pulsed during WRITE with a different base_addr -> ignored; the address sequence continues unchanged.

Source files
------------

// File: rtl/quant_writeback_if.sv
// Row-input handshake and SRAM write port of quant_writeback.
// The master drives rows (upstream), the slave is the write-back block.
interface quant_writeback_if #(
    parameter int unsigned ARRAY_SIZE        = 16,
    parameter int unsigned OUTPUT_DATA_WIDTH = 24,
    parameter int unsigned SRAM_DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH        = 10
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] in_data;
    logic                                    sram_wen;
    logic [ADDR_WIDTH-1:0]                   sram_addr;
    logic [SRAM_DATA_WIDTH-1:0]              sram_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, sram_wen, sram_addr, sram_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/quant_writeback.sv
// Packs quantized rows into 16-bit pairs and writes them to consecutive SRAM words.
// Optional macro QWB_OVF_CHECK_EN saturates out-of-range elements and raises ovf_flag.
module quant_writeback #(
    parameter int unsigned ARRAY_SIZE        = 16,
    parameter int unsigned OUTPUT_DATA_WIDTH = 24,
    parameter int unsigned SRAM_DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH        = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           num_rows,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_flag,
    quant_writeback_if.slave      bus
);
    localparam int unsigned ELEM_W = 16;
    localparam int unsigned WORDS  = ARRAY_SIZE / 2;
    localparam int unsigned K_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned ROW_W  = ARRAY_SIZE * ELEM_W;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                     state, next_state;
    logic [ROW_W-1:0]           row_q, row_in, src_row;
    logic [K_W-1:0]             k_q, k_next;
    logic [ADDR_WIDTH-1:0]      ptr_q, addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [15:0]                rows_left_q;
    logic                       in_ready_q, in_ready_d, wen_q, wen_d;
    logic                       busy_q, busy_d, done_q, done_d;
    logic                       take_start, handshake, row_end, write_next;
    logic signed [OUTPUT_DATA_WIDTH-1:0] elem;

    assign take_start = (state == IDLE) && start;
    assign handshake  = (state == LOAD) && bus.in_valid;
    assign row_end    = (state == WRITE) && (k_q == K_W'(WORDS - 1));
    assign write_next = (next_state == WRITE);
    // First word of a row comes straight from the input, the rest from the row register
    assign src_row    = (state == LOAD) ? row_in : row_q;

`ifdef QWB_OVF_CHECK_EN
    localparam logic signed [OUTPUT_DATA_WIDTH-1:0] SAT_MAX = OUTPUT_DATA_WIDTH'(32767);
    localparam logic signed [OUTPUT_DATA_WIDTH-1:0] SAT_MIN = OUTPUT_DATA_WIDTH'(-32768);
    logic ovf_in, ovf_q;

    // Saturate each element to the signed 16-bit range
    always_comb begin
        row_in = '0;
        ovf_in = 1'b0;
        elem   = '0;
        for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
            elem = bus.in_data[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
            if (elem > SAT_MAX) begin
                row_in[i*ELEM_W +: ELEM_W] = 16'h7FFF;
                ovf_in = 1'b1;
            end else if (elem < SAT_MIN) begin
                row_in[i*ELEM_W +: ELEM_W] = 16'h8000;
                ovf_in = 1'b1;
            end else begin
                row_in[i*ELEM_W +: ELEM_W] = elem[ELEM_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  ovf_q <= 1'b0;
        else if (take_start)         ovf_q <= 1'b0;
        else if (handshake && ovf_in) ovf_q <= 1'b1;
    end

    assign ovf_flag = ovf_q;
`else
    logic unused_hi;

    // Plain truncation to the low 16 bits; upper bits are intentionally dropped
    always_comb begin
        row_in    = '0;
        unused_hi = 1'b0;
        elem      = '0;
        for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
            elem = bus.in_data[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
            row_in[i*ELEM_W +: ELEM_W] = elem[ELEM_W-1:0];
            for (int j = int'(ELEM_W); j < int'(OUTPUT_DATA_WIDTH); j++) unused_hi ^= elem[j];
        end
    end

    assign ovf_flag = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            wen_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= next_state;
            in_ready_q <= in_ready_d;
            wen_q      <= wen_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = (num_rows != 16'd0) ? LOAD : DONE;
            LOAD:    if (bus.in_valid) next_state = WRITE;
            WRITE:   if (row_end) next_state = (rows_left_q > 16'd1) ? LOAD : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        in_ready_d = 1'b0;
        wen_d      = 1'b0;
        done_d     = 1'b0;
        busy_d     = (next_state != IDLE);
        k_next     = '0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        unique case (next_state)
            LOAD:  in_ready_d = 1'b1;
            WRITE: begin
                wen_d   = 1'b1;
                k_next  = (state == WRITE) ? k_q + K_W'(1) : '0;
                addr_d  = ptr_q;
                wdata_d = src_row[int'(k_next)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Row buffer, word index, address pointer and row count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= '0;
            k_q         <= '0;
            ptr_q       <= '0;
            rows_left_q <= '0;
        end else begin
            if (handshake)  row_q <= row_in;
            if (write_next) k_q <= k_next;
            if (take_start) ptr_q <= base_addr;
            else if (write_next) ptr_q <= ptr_q + ADDR_WIDTH'(1);
            if (take_start) rows_left_q <= num_rows;
            else if (row_end) rows_left_q <= rows_left_q - 16'd1;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.sram_wen   = wen_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_quant_writeback.sv
// Directed bench for quant_writeback: address sequencing, packing, latency, reset abort.
module tb_quant_writeback;
    localparam int unsigned AS    = 16;
    localparam int unsigned ODW   = 24;
    localparam int unsigned SDW   = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned ROW_W = AS * ODW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   num_rows = '0;
    logic          busy, done, ovf_flag;

    quant_writeback_if #(.ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(ODW),
                         .SRAM_DATA_WIDTH(SDW), .ADDR_WIDTH(AW)) bus ();

    quant_writeback #(.ARRAY_SIZE(AS), .OUTPUT_DATA_WIDTH(ODW),
                      .SRAM_DATA_WIDTH(SDW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .busy(busy), .done(done), .ovf_flag(ovf_flag), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor
    logic [AW-1:0]  waddr[$];
    logic [SDW-1:0] wdata[$];
    int             wcyc[$];
    int             busy_cnt = 0, done_cnt = 0, done_cyc = 0;
    always @(negedge clk) begin
        if (bus.sram_wen) begin
            waddr.push_back(bus.sram_addr);
            wdata.push_back(bus.sram_wdata);
            wcyc.push_back(cyc);
        end
        if (busy) busy_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        waddr.delete(); wdata.delete(); wcyc.delete();
        busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    endtask

    function automatic logic [ROW_W-1:0] build_row(input int b);
        logic [ROW_W-1:0] r = '0;
        for (int i = 0; i < int'(AS); i++) r[i*ODW +: ODW] = ODW'(b + i);
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input int b, input int k);
        return {16'(b + 2*k + 1), 16'(b + 2*k)};
    endfunction

    task automatic do_start(input logic [AW-1:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_rows = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_row(input logic [ROW_W-1:0] data, output int hs_cyc);
        bit ok = 1'b0;
        hs_cyc = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = data;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; hs_cyc = cyc; end
        end
        check("handshake_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_data = '1;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int hs, hs2, rdy_cyc, stall_ok, n_at_rst;
        bit got_rdy, got12;
        logic [ROW_W-1:0] r;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_wen", 32'(bus.sram_wen), 32'd0);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_wdata", bus.sram_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf_flag), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Single row at 0x010, elem[i] = i
        clear_mon();
        do_start(10'h010, 16'd1);
        send_row(build_row(0), hs);
        wait_done();
        check("r1_count", 32'(waddr.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("r1_addr%0d", k), 32'(waddr[k]), 32'h010 + 32'(k));
            check($sformatf("r1_data%0d", k), wdata[k], exp_word(0, k));
        end
        check("r1_word0", wdata[0], 32'h0001_0000);
        check("r1_word7", wdata[7], 32'h000F_000E);
        check("r1_first_lat", 32'(wcyc[0] - hs), 32'd1);
        check("r1_done_lat", 32'(done_cyc - wcyc[7]), 32'd1);
        check("r1_done_cnt", 32'(done_cnt), 32'd1);

        // Zero rows: no writes, one busy cycle, one done pulse
        clear_mon();
        do_start(10'h055, 16'd0);
        wait_done();
        repeat (3) @(negedge clk);
        #1;
        check("z_count", 32'(waddr.size()), 32'd0);
        check("z_busy_cycles", 32'(busy_cnt), 32'd1);
        check("z_done_cnt", 32'(done_cnt), 32'd1);

        // Two rows across the address wrap with a 5-cycle stall in between
        clear_mon();
        do_start(10'h3FC, 16'd2);
        send_row(build_row(32'h100), hs);
        got_rdy = 1'b0; rdy_cyc = 0;
        for (int i = 0; i < 50 && !got_rdy; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin got_rdy = 1'b1; rdy_cyc = cyc; end
        end
        check("w_ready_lat", 32'(rdy_cyc - hs), 32'd9);
        stall_ok = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.in_ready) stall_ok++;
        end
        check("w_ready_stall", 32'(stall_ok), 32'd5);
        send_row(build_row(32'h200), hs2);
        wait_done();
        check("w_count", 32'(waddr.size()), 32'd16);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("w_addr%0d", j), 32'(waddr[j]), 32'((32'h3FC + j) % 1024));
            check($sformatf("w_data%0d", j), wdata[j],
                  (j < 8) ? exp_word(32'h100, j) : exp_word(32'h200, j - 8));
        end

        // Out-of-range elements
        clear_mon();
        do_start(10'h020, 16'd1);
        r = '0;
        r[0 +: ODW]   = ODW'(40000);
        r[ODW +: ODW] = ODW'(-40000);
        send_row(r, hs);
        wait_done();
`ifdef QWB_OVF_CHECK_EN
        check("ovf_word0", wdata[0], 32'h8000_7FFF);
        check("ovf_flag", 32'(ovf_flag), 32'd1);
`else
        check("ovf_word0", wdata[0], 32'h63C0_9C40);
        check("ovf_flag", 32'(ovf_flag), 32'd0);
`endif
        check("ovf_word1", wdata[1], 32'd0);

        // Reset during word 3 of the second row
        clear_mon();
        do_start(10'h100, 16'd2);
        send_row(build_row(0), hs);
        send_row(build_row(32'h40), hs2);
        got12 = 1'b0;
        for (int i = 0; i < 50 && !got12; i++) begin
            @(negedge clk); #1;
            if (waddr.size() >= 12) got12 = 1'b1;
        end
        check("ra_reach_word3", 32'(got12), 32'd1);
        check("ra_word3_addr", 32'(waddr[11]), 32'h10B);
        #1; rst_n = 1'b0;
        #1;
        check("ra_wen", 32'(bus.sram_wen), 32'd0);
        check("ra_addr", 32'(bus.sram_addr), 32'd0);
        check("ra_wdata", bus.sram_wdata, 32'd0);
        check("ra_busy", 32'(busy), 32'd0);
        check("ra_in_ready", 32'(bus.in_ready), 32'd0);
        n_at_rst = waddr.size();
        repeat (3) @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("ra_no_writes", 32'(waddr.size()), 32'(n_at_rst));
        check("ra_idle_busy", 32'(busy), 32'd0);
        clear_mon();
        do_start(10'h000, 16'd1);
        send_row(build_row(7), hs);
        wait_done();
        check("ra_new_count", 32'(waddr.size()), 32'd8);
        check("ra_new_addr0", 32'(waddr[0]), 32'h000);
        check("ra_new_data0", wdata[0], 32'h0008_0007);

        // Start during WRITE is ignored
        clear_mon();
        do_start(10'h200, 16'd1);
        send_row(build_row(32'h30), hs);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h300; num_rows = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        #1;
        check("ig_count", 32'(waddr.size()), 32'd8);
        check("ig_addr0", 32'(waddr[0]), 32'h200);
        check("ig_addr7", 32'(waddr[7]), 32'h207);
        check("ig_done_cnt", 32'(done_cnt), 32'd1);
        check("ig_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
